// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and bit-level helpers for the pipelined ripple-carry adder.
package pipelined_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 4;

    typedef struct packed {
        logic c;
        logic s;
    } fa_t;

    function automatic fa_t full_add(input logic a, input logic b, input logic c);
        fa_t r;
        r.s = a ^ b ^ c;
        r.c = (a & b) | (c & (a ^ b));
        return r;
    endfunction

    // Carry into the MSB is recoverable as a^b^s at that bit, so overflow needs no extra tap.
    function automatic logic ovf_msb(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic cout);
        return (a_msb ^ b_msb ^ s_msb) ^ cout;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result channels of the pipelined adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder_rca_slice.sv
// Combinational SW-bit ripple-carry slice built from full-adder cells.
module rca_slice
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_s,
    output logic          o_cout
);
    logic [SW:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SW; i++) begin : g_bit
        fa_t w_fa;
        assign w_fa       = full_add(i_a[i], i_b[i], w_c[i]);
        assign o_s[i]     = w_fa.s;
        assign w_c[i+1]   = w_fa.c;
    end

    assign o_cout = w_c[SW];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SW-bit slice per stage, carry forwarded, valid/ready both sides.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipelined_adder_if.slave  bus
);
    localparam int unsigned SW = WIDTH / STAGES;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // w_rdy[k] is the ready into stage k; w_rdy[STAGES] is the consumer.
    logic [STAGES:0] w_rdy;
    assign w_rdy[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned IN_W  = WIDTH - k * SW;
        localparam int unsigned REM_W = IN_W - SW;
        localparam int unsigned SUM_W = (k + 1) * SW;

        logic             w_vin;
        logic             w_cin;
        logic [IN_W-1:0]  w_ain;
        logic [IN_W-1:0]  w_bin;
        logic [SW-1:0]    w_s;
        logic             w_cout;
        logic [SUM_W-1:0] w_sum_nxt;
        logic             r_valid;
        logic             r_carry;
        logic [SUM_W-1:0] r_sum;

        if (k == 0) begin : g_head
            assign w_vin     = bus.in_valid;
            assign w_cin     = bus.cin;
            assign w_ain     = bus.a;
            assign w_bin     = bus.b;
            assign w_sum_nxt = w_s;
        end else begin : g_body
            assign w_vin     = g_stage[k-1].r_valid;
            assign w_cin     = g_stage[k-1].r_carry;
            assign w_ain     = g_stage[k-1].g_fwd.r_a;
            assign w_bin     = g_stage[k-1].g_fwd.r_b;
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        rca_slice #(.SW(SW)) u_slice (
            .i_a    (w_ain[SW-1:0]),
            .i_b    (w_bin[SW-1:0]),
            .i_cin  (w_cin),
            .o_s    (w_s),
            .o_cout (w_cout)
        );

        assign w_rdy[k] = ~r_valid | w_rdy[k+1];

        // Stage valid, carry and accumulated low sum bits; bubbles leave data untouched.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_rdy[k]) begin
                r_valid <= w_vin;
                if (w_vin) begin
                    r_carry <= w_cout;
                    r_sum   <= w_sum_nxt;
                end
            end
        end

        if (REM_W > 0) begin : g_fwd
            logic [REM_W-1:0] r_a;
            logic [REM_W-1:0] r_b;

            // Operand bits not yet consumed travel alongside the partial sum.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_rdy[k] && w_vin) begin
                    r_a <= w_ain[IN_W-1:SW];
                    r_b <= w_bin[IN_W-1:SW];
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic r_ovf;

            // Signed overflow is only meaningful once the MSB slice has been added.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ovf <= 1'b0;
                end else if (w_rdy[k] && w_vin) begin
                    r_ovf <= ovf_msb(w_ain[SW-1], w_bin[SW-1], w_s[SW-1], w_cout);
                end
            end
        end
    end

    assign bus.in_ready  = w_rdy[0] & ~i_rst;
    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_carry;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.r_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, streaming, backpressure, reset, alt builds.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) bus ();
    pipelined_adder_if #(.WIDTH(8))  bus8 ();
    pipelined_adder_if #(.WIDTH(32)) bus32 ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut   (.i_clk(clk), .i_rst(rst), .bus(bus));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
    pipelined_adder #(.WIDTH(32), .STAGES(8)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vecs [10];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q [$];
    int          n_out;
    logic [15:0] cur_a, cur_b;
    logic        cur_cin;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        logic        v;
        t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        v = (a[15] == b[15]) && (t[15] != a[15]);
        return {t[16], v, t[15:0]};
    endfunction

    task automatic new_op();
        cur_a   = 16'($urandom);
        cur_b   = 16'($urandom);
        cur_cin = 1'($urandom);
    endtask

    // One isolated op: exact 4-cycle latency and a single-cycle result pulse.
    task automatic run_single(input vec_t v, input string tag);
        logic early;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.a = v.a; bus.b = v.b; bus.cin = v.cin;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        early = 1'b0;
        for (int n = 1; n < 4; n++) begin
            if (bus.out_valid) early = 1'b1;
            tick();
        end
        check({tag, "_early"}, early, 1'b0);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_sum"}, bus.sum, v.sum);
        check({tag, "_cout"}, bus.cout, v.cout);
        check({tag, "_ovf"}, bus.ovf, v.ovf);
        tick();
        check({tag, "_pulse"}, bus.out_valid, 1'b0);
    endtask

    // One handshake cycle with scoreboard; entered and left at posedge+1.
    task automatic step(input logic vld, input logic ordy, output logic acc);
        logic [17:0] e;
        bus.in_valid = vld; bus.a = cur_a; bus.b = cur_b; bus.cin = cur_cin;
        bus.out_ready = ordy;
        #1;
        acc = vld && bus.in_ready;
        if (bus.out_valid && ordy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("stream_extra_result", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("stream_result", {bus.cout, bus.ovf, bus.sum}, e);
            end
        end
        if (acc) exp_q.push_back(model(cur_a, cur_b, cur_cin));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic        seen;
        int          sent;
        int          accepts;
        int          lat;
        logic [17:0] held;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b1, 16'h2202, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[9] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        bus.in_valid = 1'b0; bus.a = 16'd0; bus.b = 16'd0; bus.cin = 1'b0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0; bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0; bus32.cin = 1'b0;
        bus32.out_ready = 1'b1;

        rst = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, 16'h0000);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1'b1);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream at full rate.
        n_out = 0;
        new_op();
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, acc);
            check("stream_in_ready", acc, 1'b1);
            if (acc) new_op();
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 1'b1, acc);
        check("stream_drained", exp_q.size(), 0);
        check("stream_count", n_out, 64);

        // Stall the consumer for 6 cycles while the producer keeps offering.
        n_out = 0; sent = 0; accepts = 0; held = 18'd0;
        new_op();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                check("bp_out_valid", bus.out_valid, 1'b1);
                held = {bus.cout, bus.ovf, bus.sum};
            end
            if (i == 5) check("bp_hold_1", {bus.cout, bus.ovf, bus.sum}, held);
            step(1'b1, 1'b0, acc);
            if (acc) begin accepts++; sent++; new_op(); end
        end
        check("bp_hold_2", {bus.cout, bus.ovf, bus.sum}, held);
        check("bp_accepts", accepts, 4);
        check("bp_in_ready_low", bus.in_ready, 1'b0);
        for (int i = 0; i < 60 && (sent < 12 || exp_q.size() > 0); i++) begin
            step(sent < 12, 1'b1, acc);
            if (acc) begin sent++; new_op(); end
        end
        check("bp_drained", exp_q.size(), 0);
        check("bp_count", n_out, 12);

        // Reset with three ops in flight: none may emerge.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_ghost", seen, 1'b0);
        run_single(vecs[0], "post_rst");

        // Single-stage 8-bit build.
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check("w8_valid", bus8.out_valid, 1'b1);
        check("w8_sum", bus8.sum, 8'h80);
        check("w8_cout", bus8.cout, 1'b0);
        check("w8_ovf", bus8.ovf, 1'b1);
        tick();
        check("w8_pulse", bus8.out_valid, 1'b0);

        // Eight-stage 32-bit build.
        bus32.a = 32'h12345678; bus32.b = 32'h9ABCDEF0; bus32.cin = 1'b1; bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("w32_latency", lat, 8);
        check("w32_sum", bus32.sum, 32'hACF13569);
        check("w32_cout", bus32.cout, 1'b0);
        check("w32_ovf", bus32.ovf, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
